// File: rtl/fpu_wb_pipeline.sv
// fpu_wb_pipeline: in-order write-back pipeline for the float unit.
// Carries each accepted FP instruction through DEPTH stages. Each execution
// unit's result is merged at that unit's latency stage, and a single
// register-file write port is driven from stage DEPTH. RAW hazards against
// in-flight writers stall issue.
// Optional build macro FPU_FWD_EN: forwards ready in-flight results to the
// issue stage, so that a source whose youngest producer has its value does
// not stall.
module fpu_wb_pipeline #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 5,
    parameter int LAT_CVT    = 1,
    parameter int LAT_LOAD   = 2,
    parameter int LAT_ADDSUB = 3,
    parameter int LAT_MUL    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [2:0]                    issue_op,
    input  logic [ADDR_W-1:0]             issue_rd,
    input  logic [ADDR_W-1:0]             issue_rs1,
    input  logic [ADDR_W-1:0]             issue_rs2,
    input  logic                          issue_rs1_used,
    input  logic                          issue_rs2_used,
    input  logic [DATA_W-1:0]             cvt_data,
    input  logic [DATA_W-1:0]             load_data,
    input  logic [DATA_W-1:0]             addsub_data,
    input  logic [DATA_W-1:0]             mul_data,
    output logic                          wb_en,
    output logic [ADDR_W-1:0]             wb_addr,
    output logic [DATA_W-1:0]             wb_data,
`ifdef FPU_FWD_EN
    output logic                          fwd1_valid,
    output logic [DATA_W-1:0]             fwd1_data,
    output logic                          fwd2_valid,
    output logic [DATA_W-1:0]             fwd2_data,
`endif
    output logic [$clog2(DEPTH+1)-1:0]    inflight
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_CVT    = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_ADDSUB = 3'd3;
    localparam logic [2:0] OP_MUL    = 3'd4;

    // Every unit must deliver its result somewhere inside the pipeline.
    if (LAT_CVT < 1 || LAT_CVT > DEPTH || LAT_LOAD < 1 || LAT_LOAD > DEPTH ||
        LAT_ADDSUB < 1 || LAT_ADDSUB > DEPTH || LAT_MUL < 1 || LAT_MUL > DEPTH) begin : g_bad_lat
        $error("fpu_wb_pipeline: every LAT_* must lie in 1..DEPTH");
    end

    // Stage state, indexed by stage number 1..DEPTH.
    logic [DEPTH:1]             stg_valid;
    logic [DEPTH:1][2:0]        stg_op;
    logic [DEPTH:1][ADDR_W-1:0] stg_rd;
    logic [DEPTH:1][DATA_W-1:0] stg_data;

    logic [DEPTH:1][DATA_W-1:0] merged;
    logic [DEPTH:1]             writing;
    logic [2:0]                 op_n;
    logic                       accept;
    logic                       stall1, stall2;
    logic [CNT_W-1:0]           nxt_cnt;

    // Undefined opcodes 5-7 behave as "no FP write".
    assign op_n   = (issue_op > OP_MUL) ? OP_NONE : issue_op;
    assign accept = issue_valid && issue_ready;

    // Stage at which an op's result becomes part of the carried data.
    function automatic int lat_of(input logic [2:0] op);
        case (op)
            OP_CVT:    return LAT_CVT;
            OP_LOAD:   return LAT_LOAD;
            OP_ADDSUB: return LAT_ADDSUB;
            OP_MUL:    return LAT_MUL;
            default:   return 0;
        endcase
    endfunction

    // Per-stage data after the unit result merge; feeds the next stage and wb.
    always_comb begin
        merged  = stg_data;
        writing = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            writing[k] = stg_valid[k] && (stg_op[k] != OP_NONE);
            if (stg_op[k] == OP_CVT    && k == LAT_CVT)    merged[k] = cvt_data;
            if (stg_op[k] == OP_LOAD   && k == LAT_LOAD)   merged[k] = load_data;
            if (stg_op[k] == OP_ADDSUB && k == LAT_ADDSUB) merged[k] = addsub_data;
            if (stg_op[k] == OP_MUL    && k == LAT_MUL)    merged[k] = mul_data;
        end
    end

`ifdef FPU_FWD_EN
    logic              f1_hit, f1_rdy, f2_hit, f2_rdy;
    logic [DATA_W-1:0] f1_val, f2_val;

    // Youngest matching writer per source; scan oldest-first so the last hit wins.
    always_comb begin
        f1_hit = 1'b0; f1_rdy = 1'b0; f1_val = '0;
        f2_hit = 1'b0; f2_rdy = 1'b0; f2_val = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (writing[k] && stg_rd[k] == issue_rs1) begin
                f1_hit = 1'b1;
                f1_rdy = (k > lat_of(stg_op[k])) || (k == DEPTH);
                f1_val = merged[k];
            end
            if (writing[k] && stg_rd[k] == issue_rs2) begin
                f2_hit = 1'b1;
                f2_rdy = (k > lat_of(stg_op[k])) || (k == DEPTH);
                f2_val = merged[k];
            end
        end
    end

    assign stall1     = issue_rs1_used && f1_hit && !f1_rdy;
    assign stall2     = issue_rs2_used && f2_hit && !f2_rdy;
    assign fwd1_valid = !rst && issue_rs1_used && f1_hit && f1_rdy;
    assign fwd2_valid = !rst && issue_rs2_used && f2_hit && f2_rdy;
    assign fwd1_data  = fwd1_valid ? f1_val : '0;
    assign fwd2_data  = fwd2_valid ? f2_val : '0;
`else
    // Any in-flight writer of a used source blocks issue (regfile has no bypass).
    always_comb begin
        stall1 = 1'b0;
        stall2 = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (writing[k] && issue_rs1_used && stg_rd[k] == issue_rs1) stall1 = 1'b1;
            if (writing[k] && issue_rs2_used && stg_rd[k] == issue_rs2) stall2 = 1'b1;
        end
    end
`endif

    // Reset discards everything, so issue is never blocked while it is held.
    assign issue_ready = rst || !(stall1 || stall2);

    assign wb_en   = writing[DEPTH] && !rst;
    assign wb_addr = wb_en ? stg_rd[DEPTH] : '0;
    assign wb_data = wb_en ? merged[DEPTH] : '0;

    // Number of writers that will occupy stages 1..DEPTH after this edge.
    always_comb begin
        nxt_cnt = (accept && op_n != OP_NONE) ? CNT_W'(1) : '0;
        for (int k = 1; k < DEPTH; k++)
            nxt_cnt = nxt_cnt + CNT_W'(writing[k]);
    end

    // Shift every stage forward each cycle; stage 1 takes the issue or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= '0;
            stg_op    <= '0;
            stg_rd    <= '0;
            stg_data  <= '0;
            inflight  <= '0;
        end else begin
            stg_valid[1] <= accept;
            stg_op[1]    <= accept ? op_n : OP_NONE;
            stg_rd[1]    <= accept ? issue_rd : '0;
            stg_data[1]  <= '0;
            for (int k = 2; k <= DEPTH; k++) begin
                stg_valid[k] <= stg_valid[k-1];
                stg_op[k]    <= stg_op[k-1];
                stg_rd[k]    <= stg_rd[k-1];
                stg_data[k]  <= merged[k-1];
            end
            inflight <= nxt_cnt;
        end
    end

endmodule
